clk_gate_ctrl: RTL

- Sequencer that drives the E and TE pins of one standard clock-gate cell. That cell is instantiated by the parent, not inside this block.
- Sits in the always-on clock domain next to the gate cell.
- N requesters ask for the gated domain. The block opens the gate, waits a fixed settle time, then acknowledges.
- When all demand disappears for a hysteresis window, it closes the gate again.
- A DFT test-enable and a software force-on override the sequencing.

---
 rtl/clk_gate_ctrl_pkg.sv | 20 ++
 rtl/cg_down_counter.sv | 29 ++
 rtl/clk_gate_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and helpers for the clock-gate sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package clk_gate_ctrl_pkg;

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      WAKE  = 2'd1,
      ON    = 2'd2,
      DRAIN = 2'd3
   } cg_state_e;

   // Width of the shared WAKE/DRAIN down-counter: it must hold max(wake, idle).
   function automatic int cg_cnt_width(input int wake_cycles, input int idle_cycles);
      int max_cycles;
      max_cycles = (wake_cycles > idle_cycles) ? wake_cycles : idle_cycles;
      return $clog2(max_cycles + 1);
   endfunction

endpackage

// File: rtl/cg_down_counter.sv
// Loadable down-counter with zero flag; load has priority over decrement.
// Latency: load/decrement take effect on the next clock edge; zero is combinational.
// Backpressure: none; decrement saturates at zero.
module cg_down_counter #(
   parameter int WIDTH = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] cnt_q;

   assign zero = (cnt_q == '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && !zero) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Sequences E/TE of an external clock-gate cell: wake, settle, ack, drain with hysteresis.
// Latency: ack WAKE_CYCLES edges after demand is sampled; cg_en drops IDLE_CYCLES edges after keep falls.
// Backpressure: busy holds the gate open but never wakes it; dft_te bypasses sequencing via TE.
module clk_gate_ctrl
   import clk_gate_ctrl_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int WAKE_CYCLES = 2,
   parameter int IDLE_CYCLES = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] ack,
   input  logic               busy,
   input  logic               force_on,
   input  logic               dft_te,
   output logic               cg_en,
   output logic               cg_te,
   output logic               gate_on
);

   localparam int CNT_W = cg_cnt_width(WAKE_CYCLES, IDLE_CYCLES);
   localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
   localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);

   cg_state_e        state_q;
   cg_state_e        state_d;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_load_val;
   logic             cnt_dec;
   logic             cnt_zero;
   logic             demand;
   logic             keep;

   assign demand = (|req) | force_on;
   assign keep   = demand | busy;

   cg_down_counter #(
      .WIDTH (CNT_W)
   ) u_cnt (
      .clock    (clock),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d      = state_q;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_dec      = 1'b0;
      unique case (state_q)
         OFF: begin
            if (demand) begin
               state_d      = WAKE;
               cnt_load     = 1'b1;
               cnt_load_val = WAKE_LOAD;
            end
         end
         // Dropping demand here does not abort; the domain settles and then drains.
         WAKE: begin
            if (cnt_zero) begin
               state_d = ON;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ON: begin
            if (!keep) begin
               state_d      = DRAIN;
               cnt_load     = 1'b1;
               cnt_load_val = IDLE_LOAD;
            end
         end
         DRAIN: begin
            if (keep) begin
               state_d = ON;
            end else if (cnt_zero) begin
               state_d = OFF;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: state_d = OFF;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= OFF;
         cg_en   <= 1'b0;
      end else begin
         state_q <= state_d;
         cg_en   <= (state_d != OFF);
      end
   end

   // TE path is deliberately outside the FSM so scan never depends on sequencer state.
   assign cg_te   = dft_te;
   assign ack     = (state_q == ON) ? req : '0;
   assign gate_on = (state_q == ON) || (state_q == DRAIN);

endmodule
